// File: rtl/wb_arb_pkg.sv
// Shared constants and types for the write-back port arbiter.
// Optional forwarding outputs are enabled with the WB_ARB_FWD_EN macro.
package wb_arb_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 32;

  localparam logic SRC_ALU = 1'b0;
  localparam logic SRC_MEM = 1'b1;

  // Write request bundle at the default widths.
  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester arbiter: round-robin pointer or fixed priority to requester 1,
// with a stall input that blocks every grant and freezes the pointer.
module rr_arb2
  import wb_arb_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_stall,
  input  logic [1:0] i_req,
  output logic [1:0] o_grant
);

  logic       r_ptr;
  logic [1:0] w_grant;

  // Grants are forced low while reset is asserted so ready never leaks out.
  always_comb begin
    w_grant = 2'b00;
    if (rst_n && !i_stall) begin
      case (i_req)
        2'b01:   w_grant = 2'b01;
        2'b10:   w_grant = 2'b10;
        2'b11: begin
          if (FIXED_PRIO != 0) w_grant = 2'b10;
          else if (r_ptr)      w_grant = 2'b10;
          else                 w_grant = 2'b01;
        end
        default: w_grant = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= 1'b0;
    end else if (w_grant[0]) begin
      r_ptr <= 1'b1;
    end else if (w_grant[1]) begin
      r_ptr <= 1'b0;
    end
  end

  assign o_grant = w_grant;

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the ALU (0) and load (1) paths.
// Define WB_ARB_FWD_EN to add same-cycle forwarding outputs (fwd_*).
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_stall,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
`ifdef WB_ARB_FWD_EN
  output logic              fwd_valid,
  output logic [ADDR_W-1:0] fwd_reg,
  output logic [DATA_W-1:0] fwd_data,
`endif
  output logic              reg_write,
  output logic [ADDR_W-1:0] write_reg,
  output logic [DATA_W-1:0] write_data,
  output logic              src_sel
);

  logic [1:0]        w_grant;
  logic              w_xfer;
  logic              w_sel;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  logic              w_nonzero;

  logic              r_reg_write;
  logic [ADDR_W-1:0] r_write_reg;
  logic [DATA_W-1:0] r_write_data;
  logic              r_src_sel;

  rr_arb2 #(
    .FIXED_PRIO (FIXED_PRIO)
  ) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_stall (wb_stall),
    .i_req   ({req1_valid, req0_valid}),
    .o_grant (w_grant)
  );

  assign w_xfer    = |w_grant;
  assign w_sel     = w_grant[1] ? SRC_MEM : SRC_ALU;
  assign w_addr    = w_grant[1] ? req1_addr : req0_addr;
  assign w_data    = w_grant[1] ? req1_data : req0_data;
  assign w_nonzero = (w_addr != '0);

  // Writes to register 0 are consumed but never reach the register file.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_reg_write  <= 1'b0;
      r_write_reg  <= '0;
      r_write_data <= '0;
      r_src_sel    <= SRC_ALU;
    end else begin
      r_reg_write <= w_xfer && w_nonzero;
      if (w_xfer) begin
        r_write_reg  <= w_addr;
        r_write_data <= w_data;
        r_src_sel    <= w_sel;
      end
    end
  end

  assign req0_ready = w_grant[0];
  assign req1_ready = w_grant[1];
  assign reg_write  = r_reg_write;
  assign write_reg  = r_write_reg;
  assign write_data = r_write_data;
  assign src_sel    = r_src_sel;

`ifdef WB_ARB_FWD_EN
  assign fwd_valid = w_xfer && w_nonzero;
  assign fwd_reg   = w_addr;
  assign fwd_data  = w_data;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: a round-robin and a fixed-priority
// instance share one stimulus stream; expectations are hand-computed.
module tb_wb_port_arbiter;
  import wb_arb_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        wb_stall;
  logic        req0_valid;
  logic        req1_valid;
  wb_req_t     req0;
  wb_req_t     req1;

  logic        rr_ready0, rr_ready1, rr_we, rr_src;
  logic [4:0]  rr_wreg;
  logic [31:0] rr_wdata;
  logic        fp_ready0, fp_ready1, fp_we, fp_src;
  logic [4:0]  fp_wreg;
  logic [31:0] fp_wdata;
`ifdef WB_ARB_FWD_EN
  logic        rr_fv, fp_fv;
  logic [4:0]  rr_fr, fp_fr;
  logic [31:0] rr_fd, fp_fd;
`endif

  int checks;
  int errors;

  wb_port_arbiter #(.ADDR_W(5), .DATA_W(32), .FIXED_PRIO(0)) dutRr (
    .clk(clk), .rst_n(rst_n), .wb_stall(wb_stall),
    .req0_valid(req0_valid), .req0_addr(req0.addr), .req0_data(req0.data), .req0_ready(rr_ready0),
    .req1_valid(req1_valid), .req1_addr(req1.addr), .req1_data(req1.data), .req1_ready(rr_ready1),
`ifdef WB_ARB_FWD_EN
    .fwd_valid(rr_fv), .fwd_reg(rr_fr), .fwd_data(rr_fd),
`endif
    .reg_write(rr_we), .write_reg(rr_wreg), .write_data(rr_wdata), .src_sel(rr_src)
  );

  wb_port_arbiter #(.ADDR_W(5), .DATA_W(32), .FIXED_PRIO(1)) dutFp (
    .clk(clk), .rst_n(rst_n), .wb_stall(wb_stall),
    .req0_valid(req0_valid), .req0_addr(req0.addr), .req0_data(req0.data), .req0_ready(fp_ready0),
    .req1_valid(req1_valid), .req1_addr(req1.addr), .req1_data(req1.data), .req1_ready(fp_ready1),
`ifdef WB_ARB_FWD_EN
    .fwd_valid(fp_fv), .fwd_reg(fp_fr), .fwd_data(fp_fd),
`endif
    .reg_write(fp_we), .write_reg(fp_wreg), .write_data(fp_wdata), .src_sel(fp_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkReady(input string tag, input logic r0, input logic r1, input logic f0, input logic f1);
    checkOutput({tag, " rr ready"}, {62'd0, rr_ready1, rr_ready0}, {62'd0, r1, r0});
    checkOutput({tag, " fp ready"}, {62'd0, fp_ready1, fp_ready0}, {62'd0, f1, f0});
  endtask

  task automatic checkPort(input string tag, input bit fixedPrio, input logic we,
                           input logic [4:0] wreg, input logic [31:0] wdata, input logic src);
    if (fixedPrio) begin
      checkOutput({tag, " fp we"},   {63'd0, fp_we},    {63'd0, we});
      checkOutput({tag, " fp reg"},  {59'd0, fp_wreg},  {59'd0, wreg});
      checkOutput({tag, " fp data"}, {32'd0, fp_wdata}, {32'd0, wdata});
      checkOutput({tag, " fp src"},  {63'd0, fp_src},   {63'd0, src});
    end else begin
      checkOutput({tag, " rr we"},   {63'd0, rr_we},    {63'd0, we});
      checkOutput({tag, " rr reg"},  {59'd0, rr_wreg},  {59'd0, wreg});
      checkOutput({tag, " rr data"}, {32'd0, rr_wdata}, {32'd0, wdata});
      checkOutput({tag, " rr src"},  {63'd0, rr_src},   {63'd0, src});
    end
  endtask

  task automatic applyStimulus(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                               input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                               input logic stall);
    req0_valid = v0;
    req0.addr  = a0;
    req0.data  = d0;
    req1_valid = v1;
    req1.addr  = a1;
    req1.data  = d1;
    wb_stall   = stall;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    applyStimulus(1'b1, 5'd10, 32'hA5A5A5A5, 1'b1, 5'd7, 32'h77, 1'b0);
    #12;
    // Reset state, with requests pending to show ready stays low.
    checkReady("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    checkPort("reset", 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
    checkPort("reset", 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);

    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    nextCycle();

    // ALU only: accepted the same cycle, written one cycle later.
    applyStimulus(1'b1, 5'd10, 32'hA5A5A5A5, 1'b0, 5'd0, 32'd0, 1'b0);
    #1;
    checkReady("alu only", 1'b1, 1'b0, 1'b1, 1'b0);
    nextCycle();
    checkPort("alu only", 1'b0, 1'b1, 5'd10, 32'hA5A5A5A5, SRC_ALU);
    checkPort("alu only", 1'b1, 1'b1, 5'd10, 32'hA5A5A5A5, SRC_ALU);

    // Load to register 0: consumed, write suppressed, pointer back to 0.
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0);
    #1;
    checkReady("load r0", 1'b0, 1'b1, 1'b0, 1'b1);
    nextCycle();
    checkPort("load r0", 1'b0, 1'b0, 5'd0, 32'hFFFFFFFF, SRC_MEM);

    // Idle: write enable drops, other outputs hold.
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    #1;
    checkReady("idle", 1'b0, 1'b0, 1'b0, 1'b0);
    nextCycle();
    checkPort("idle", 1'b0, 1'b0, 5'd0, 32'hFFFFFFFF, SRC_MEM);

    // Continuous contention: rr alternates 0,1,0,1; fixed priority always picks 1.
    applyStimulus(1'b1, 5'd3, 32'h33, 1'b1, 5'd7, 32'h77, 1'b0);
    for (int i = 0; i < 4; i++) begin
      #1;
      checkReady("contend", (i % 2) == 0, (i % 2) == 1, 1'b0, 1'b1);
      nextCycle();
      if ((i % 2) == 0) checkPort("contend", 1'b0, 1'b1, 5'd3, 32'h33, SRC_ALU);
      else              checkPort("contend", 1'b0, 1'b1, 5'd7, 32'h77, SRC_MEM);
      checkPort("contend", 1'b1, 1'b1, 5'd7, 32'h77, SRC_MEM);
    end

    // Load request withdrawn: fixed-priority instance finally serves the ALU.
    applyStimulus(1'b1, 5'd3, 32'h33, 1'b0, 5'd7, 32'h77, 1'b0);
    #1;
    checkReady("load drop", 1'b1, 1'b0, 1'b1, 1'b0);
    nextCycle();
    checkPort("load drop", 1'b1, 1'b1, 5'd3, 32'h33, SRC_ALU);

    // Stall for three cycles with both requesting: nothing granted or written.
    applyStimulus(1'b1, 5'd3, 32'h33, 1'b1, 5'd7, 32'h77, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      checkReady("stall", 1'b0, 1'b0, 1'b0, 1'b0);
      nextCycle();
      checkPort("stall", 1'b0, 1'b0, 5'd3, 32'h33, SRC_ALU);
      checkPort("stall", 1'b1, 1'b0, 5'd3, 32'h33, SRC_ALU);
    end

    // Stall released: rr pointer was left at 1, so the load wins first.
    wb_stall = 1'b0;
    #1;
    checkReady("unstall", 1'b0, 1'b1, 1'b0, 1'b1);
    nextCycle();
    checkPort("unstall", 1'b0, 1'b1, 5'd7, 32'h77, SRC_MEM);

    // ALU wins next (rr pointer now 1 afterwards), then reset hits mid-write.
    #1;
    checkReady("pre reset", 1'b1, 1'b0, 1'b0, 1'b1);
    nextCycle();
    checkPort("pre reset", 1'b0, 1'b1, 5'd3, 32'h33, SRC_ALU);
    rst_n = 1'b0;
    #1;
    checkReady("mid reset", 1'b0, 1'b0, 1'b0, 1'b0);
    checkPort("mid reset", 1'b0, 1'b0, 5'd0, 32'd0, SRC_ALU);
    checkPort("mid reset", 1'b1, 1'b0, 5'd0, 32'd0, SRC_ALU);

    // After reset the rr pointer favours the ALU again.
    #1;
    rst_n = 1'b1;
    #1;
    checkReady("post reset", 1'b1, 1'b0, 1'b0, 1'b1);
    nextCycle();
    checkPort("post reset", 1'b0, 1'b1, 5'd3, 32'h33, SRC_ALU);
    checkPort("post reset", 1'b1, 1'b1, 5'd7, 32'h77, SRC_MEM);

    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    nextCycle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
